// File: rtl/plasma_ext_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : plasma_ext_mem_resp
//  Purpose  : Memory-mapped responder for the Plasma external bus. Decodes an
//             address window and serves word reads and byte-lane writes from
//             an on-chip RAM. It stalls the CPU through mem_pause for a
//             programmable number of wait states per access.
//  Revision : 1.0 - initial release
// ============================================================================
module plasma_ext_mem_resp #(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hF000_0000,
    parameter int          MEM_WORDS_LOG2 = 12,
    parameter int          WAIT_STATES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] address,
    input  logic [3:0]  byte_we,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        mem_pause,
    output logic        hit
);

    localparam int          c_DEPTH     = 1 << MEM_WORDS_LOG2;
    localparam logic [3:0]  c_WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [29:0] c_MASK      = ADDR_MASK[31:2];
    localparam logic [29:0] c_BASE      = BASE_ADDR[31:2] & ADDR_MASK[31:2];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_cnt;
    logic [MEM_WORDS_LOG2-1:0]  r_idx;
    logic [31:0]                r_rdata;

    logic                       w_hit;
    logic                       w_start;
    logic [MEM_WORDS_LOG2-1:0]  w_idx;
    logic [31:0]                w_ram_q;

    // Window decode; upper address bits beyond the RAM depth alias the RAM.
    assign w_hit   = ((address & c_MASK) == c_BASE);
    assign w_start = (r_state == ST_IDLE) && w_hit;
    assign w_idx   = address[MEM_WORDS_LOG2-1:0];

    // The RAM is split into four byte lanes so each enable gates its own array.
    // Writes commit from the live bus on the edge leaving IDLE, so only the
    // word index needs to be held for the read-back during WAIT.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [c_DEPTH];

        // Byte-lane write on the edge that leaves IDLE; blocked while reset is high.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                // RAM contents are deliberately not cleared by reset
            end else if (w_start && byte_we[g]) begin
                r_mem[w_idx] <= data_write[8*g +: 8];
            end
        end

        assign w_ram_q[8*g +: 8] = r_mem[r_idx];
    end

    // Access sequencer: capture in IDLE, count wait states, present in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_idx   <= w_idx;
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt   <= r_cnt - 4'd1;
                    // Sampled every WAIT cycle; the write already landed, so a
                    // write access returns the post-write word.
                    r_rdata <= w_ram_q;
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pause is combinational so the CPU freezes in the request cycle itself.
    assign hit       = w_hit;
    assign mem_pause = w_start || (r_state == ST_WAIT);
    assign data_read = (r_state == ST_DONE) ? r_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_plasma_ext_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plasma_ext_mem_resp
//  Purpose  : Self-checking bench for plasma_ext_mem_resp with a reference
//             word model and an expected-data queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_plasma_ext_mem_resp;

    localparam logic [29:0] c_IDLE_ADDR = 30'h0800_0000;   // byte 0x2000_0000

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] address,  address1;
    logic [3:0]  byte_we,  byte_we1;
    logic [31:0] data_write, data_write1;
    logic [31:0] data_read, data_read1;
    logic        mem_pause, mem_pause1;
    logic        hit, hit1;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    plasma_ext_mem_resp #(.WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .byte_we(byte_we),
        .data_write(data_write), .data_read(data_read),
        .mem_pause(mem_pause), .hit(hit)
    );

    plasma_ext_mem_resp #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .address(address1), .byte_we(byte_we1),
        .data_write(data_write1), .data_read(data_read1),
        .mem_pause(mem_pause1), .hit(hit1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One complete access on the WAIT_STATES=2 instance, checked cycle by cycle.
    task automatic access(input logic [31:0] baddr, input logic [3:0] we,
                          input logic [31:0] wd, input string tag);
        int          idx;
        int          n;
        logic [31:0] w;
        idx = int'(baddr[13:2]);
        if (we != 4'h0) begin
            w = model.exists(idx) ? model[idx] : 32'h0;
            for (int l = 0; l < 4; l++)
                if (we[l]) w[8*l +: 8] = wd[8*l +: 8];
            model[idx] = w;
        end
        exp_q.push_back(model[idx]);
        @(posedge clk); #1;
        address = baddr[31:2]; byte_we = we; data_write = wd;
        @(negedge clk);
        check({tag, " hit c0"}, {31'h0, hit}, 32'h1);
        check({tag, " pause c0"}, {31'h0, mem_pause}, 32'h1);
        // Garbage on the bus while paused must be ignored.
        @(posedge clk); #1;
        byte_we = 4'hF; data_write = 32'hFFFF_FFFF;
        n = 1;
        forever begin
            @(negedge clk);
            if (!mem_pause || n > 20) break;
            n++;
        end
        check({tag, " done cycle"}, 32'(n), 32'd3);
        check({tag, " data"}, data_read, exp_q.pop_front());
        address = c_IDLE_ADDR; byte_we = 4'h0; data_write = 32'h0;
        @(negedge clk);
        check({tag, " data after"}, data_read, 32'h0);
        check({tag, " pause after"}, {31'h0, mem_pause}, 32'h0);
    endtask

    // Hold one address for ncyc cycles and check the repeating pause pattern.
    task automatic back_to_back(input int ws, input logic [31:0] baddr, input logic [3:0] we,
                                input logic [31:0] wd, input logic [31:0] expv, input int ncyc);
        logic exp_p;
        logic p;
        logic [31:0] d;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if (ws == 1) begin address1 = baddr[31:2]; byte_we1 = we; data_write1 = wd; end
                else         begin address  = baddr[31:2]; byte_we  = we; data_write  = wd; end
            end else if (i == 8) begin
                address1 = c_IDLE_ADDR; address = c_IDLE_ADDR;
            end
            if (i % (ws + 2) == 0) exp_q.push_back(expv);
            @(negedge clk);
            exp_p = (i % (ws + 2)) != (ws + 1);
            p = (ws == 1) ? mem_pause1 : mem_pause;
            d = (ws == 1) ? data_read1 : data_read;
            check($sformatf("bb%0d pause c%0d", ws, i), {31'h0, p}, {31'h0, exp_p});
            if (!exp_p) check($sformatf("bb%0d data c%0d", ws, i), d, exp_q.pop_front());
            else        check($sformatf("bb%0d zero c%0d", ws, i), d, 32'h0);
        end
        @(posedge clk); #1;
        address = c_IDLE_ADDR; byte_we = 4'h0; address1 = c_IDLE_ADDR; byte_we1 = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        address = c_IDLE_ADDR;  byte_we = 4'h0;  data_write = 32'h0;
        address1 = c_IDLE_ADDR; byte_we1 = 4'h0; data_write1 = 32'h0;
        repeat (2) @(negedge clk);
        check("rst data", data_read, 32'h0);
        check("rst pause", {31'h0, mem_pause}, 32'h0);
        check("rst hit", {31'h0, hit}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle pause", {31'h0, mem_pause}, 32'h0);

        // Full write then read
        access(32'h1000_0010, 4'hF, 32'hDEADBEEF, "wr full");
        access(32'h1000_0010, 4'h0, 32'h0, "rd full");
        check("model full", model[4], 32'hDEADBEEF);

        // Byte lanes
        access(32'h1000_0010, 4'b1000, 32'h11223344, "wr lane3");
        access(32'h1000_0010, 4'h0, 32'h0, "rd lane3");
        check("model lane3", model[4], 32'h11ADBEEF);
        access(32'h1000_0010, 4'b0001, 32'h000000AA, "wr lane0");
        access(32'h1000_0010, 4'h0, 32'h0, "rd lane0");
        check("model lane0", model[4], 32'h11ADBEAA);

        // Out-of-window writes must neither respond nor touch RAM
        @(posedge clk); #1;
        address = c_IDLE_ADDR; byte_we = 4'hF; data_write = 32'h0BAD_0BAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("miss hit c%0d", i), {31'h0, hit}, 32'h0);
            check($sformatf("miss pause c%0d", i), {31'h0, mem_pause}, 32'h0);
            check($sformatf("miss data c%0d", i), data_read, 32'h0);
        end
        @(posedge clk); #1 byte_we = 4'h0; data_write = 32'h0;

        // 16 KiB alias of the same word
        access(32'h1000_4010, 4'h0, 32'h0, "rd alias");

        // Back-to-back accesses with the address held
        back_to_back(1, 32'h1000_0040, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 9);
        back_to_back(2, 32'h1000_0010, 4'h0, 32'h0, 32'h11ADBEAA, 8);

        // Reset during WAIT of a read
        @(posedge clk); #1;
        address = 30'h0400_0004; byte_we = 4'h0;
        @(negedge clk);
        check("rstw pause c0", {31'h0, mem_pause}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1; address = c_IDLE_ADDR;
        @(negedge clk);
        check("rstw pause", {31'h0, mem_pause}, 32'h0);
        check("rstw data", data_read, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        access(32'h1000_0010, 4'h0, 32'h0, "rd after rstw");

        // Write in cycle 0 with reset held must not commit
        @(posedge clk); #1;
        reset = 1'b1; address = 30'h0400_0004; byte_we = 4'hF; data_write = 32'hBAD0BAD0;
        @(negedge clk);
        check("rst0 pause", {31'h0, mem_pause}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0; address = c_IDLE_ADDR; byte_we = 4'h0; data_write = 32'h0;
        access(32'h1000_0010, 4'h0, 32'h0, "rd after rst0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plasma_ext_mem_resp.md
# plasma_ext_mem_resp

Memory-mapped responder for the Plasma CPU's external bus (`address`/`byte_we`/`data_write`/`data_read`/`mem_pause_in`), currently left unconnected on the ML605 platform. It decodes an address window and serves reads and byte-lane writes from an on-chip word RAM. It stalls the CPU through a pause output for a programmable number of wait states. It sits beside `plasma` in the platform top, on the CPU clock domain.

## Interface
- `BASE_ADDR`, 32'h1000_0000, window base; only bits [31:2] are used.
- `ADDR_MASK`, 32'hF000_0000, bits compared for decode; bits [31:2] are used.
- `MEM_WORDS_LOG2`, 12, RAM depth as log2 of 32-bit words (4096 words = 16 KiB).
- `WAIT_STATES`, 2, extra stall cycles per access; legal range 1..15.
- `clk` in 1: CPU clock (50 MHz on ML605); all logic rises on this edge.
- `reset` in 1: asynchronous, active-high.
- `address` in 30: CPU word address, bits [31:2].
- `byte_we` in 4: byte-lane write enables; [3] maps to data[31:24] (big-endian lane order); 4'b0000 means read.
- `data_write` in 32: write data.
- `data_read` out 32: read data to CPU.
- `mem_pause` out 1: stall request to CPU; connects to `plasma.mem_pause_in`.
- `hit` out 1: decode result, for debug/LEDs.

## Operation
- Decode: `hit` = ((address & ADDR_MASK[31:2]) == (BASE_ADDR[31:2] & ADDR_MASK[31:2])). It is combinational.
- RAM index is address[MEM_WORDS_LOG2+1:2]. Windows larger than the RAM alias (wrap) modulo depth.
- FSM states:
  - IDLE:
    - On `hit`: capture address, byte_we, data_write. Load the wait counter with WAIT_STATES. Go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT: decrement the counter each cycle. When the counter reaches 1 (last WAIT cycle), go to DONE.
  - DONE: present the response for one cycle, then go to IDLE unconditionally.
- Write: the RAM is written with the captured byte lanes on the edge that leaves IDLE. Lanes with byte_we bit 0 are preserved.
- Read: RAM is read at the captured index during WAIT. The result is registered into the data_read register before DONE.
- On a write access, DONE still occurs; data_read then shows the post-write word.
- `mem_pause` = (state==IDLE && hit) || state==WAIT. It is combinational so the CPU freezes in the request cycle. It is 0 in DONE.
- `data_read` = registered word in DONE, 32'h0 otherwise.
- An address held by the CPU after DONE is treated as a new access (back-to-back). Every access costs WAIT_STATES+2 cycles.
- Inputs are ignored outside IDLE. Changes to address or byte_we while paused have no effect.

## Timing
- Reset values:
  - State: IDLE.
  - Counter: 0.
  - Captured registers: 0.
  - `data_read`: 0.
  - `mem_pause`: 0 (unless `hit` combinationally).
  - RAM contents: not reset.
- Access cycle sequence, with cycle 0 being IDLE with hit:
  - Cycle 0: pause=1.
  - Cycles 1..WAIT_STATES: WAIT, pause=1.
  - Cycle WAIT_STATES+1: DONE, pause=0, data valid.
  - Cycle WAIT_STATES+2: IDLE; a new access may start here.
- Write commit edge: end of cycle 0.
- Reset asserted mid-access: immediate return to IDLE, pause drops (apart from combinational hit), data_read becomes 0.
  - A write whose commit edge passed stays committed.
  - A write in cycle 0 with reset asserted is not committed.
- Non-hit cycles: pause=0, data_read=0, no RAM activity.

## Test plan
- Reset (WAIT_STATES=2): with reset high and no hit -> data_read=0, mem_pause=0. Deassert reset -> state IDLE.
- Full write then read at 0x1000_0010:
  - Write: byte_we=4'hF, data_write=32'hDEADBEEF -> pause high for cycles 0..2, low in cycle 3.
  - Read: byte_we=0 -> data_read=32'hDEADBEEF exactly in cycle 3, 0 in cycle 4.
- Byte lanes: over the same word, write byte_we=4'b1000 with 32'h11223344 -> read returns 32'h11ADBEEF. Then write byte_we=4'b0001 with 32'h000000AA -> read returns 32'h11ADBEAA.
- Decode and alias:
  - Address 0x2000_0000 -> hit=0, pause=0, data_read=0 for 10 cycles, RAM unchanged.
  - Address 0x1000_4010 (16 KiB alias) -> reads 32'h11ADBEAA.
- Back-to-back and WAIT_STATES=1: hold address for 8 cycles -> pause pattern 1,1,0,1,1,0,1,1. Data valid on every 0 cycle.
- Reset in WAIT during a read -> next cycle pause=0 (address non-hit), data_read=0. A following read of the written word returns the committed value.
